// File: rtl/thirty_two_bit_adder.sv
// thirty_two_bit_adder: registered 32-bit two-level carry-lookahead adder
module thirty_two_bit_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] sum,
    output logic        Cout
);
    logic [31:0] p, g, c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;
    logic        pp;
    assign p = A ^ B;
    assign g = A & B;
    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : grp
            logic [3:0] gp4, gg4;
            logic       ci;
            assign gp4 = p[4*i +: 4];
            assign gg4 = g[4*i +: 4];
            assign ci  = gc[i];
            assign c[4*i]   = ci;
            assign c[4*i+1] = gg4[0] | (gp4[0] & ci);
            assign c[4*i+2] = gg4[1] | (gp4[1] & gg4[0]) | (gp4[1] & gp4[0] & ci);
            assign c[4*i+3] = gg4[2] | (gp4[2] & gg4[1]) | (gp4[2] & gp4[1] & gg4[0])
                            | (gp4[2] & gp4[1] & gp4[0] & ci);
            assign gg[i] = gg4[3] | (gp4[3] & gg4[2]) | (gp4[3] & gp4[2] & gg4[1])
                         | (gp4[3] & gp4[2] & gp4[1] & gg4[0]);
            assign gp[i] = &gp4;
        end
    endgenerate
    // each group carry is a flat sum of products over lower (G, P) pairs and Cin
    always_comb begin
        gc = '0;
        pp = 1'b1;
        gc[0] = Cin;
        for (int k = 1; k < 9; k++) begin
            pp = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                gc[k] = gc[k] | (pp & gg[j]);
                pp = pp & gp[j];
            end
            gc[k] = gc[k] | (pp & Cin);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            Cout <= 1'b0;
        end else begin
            sum  <= p ^ c;
            Cout <= gc[8];
        end
    end
endmodule

// File: tb/tb_thirty_two_bit_adder.sv
// tb_thirty_two_bit_adder: directed and randomized checks against a 33-bit arithmetic model
module tb_thirty_two_bit_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic [31:0] sum;
    logic        cout;
    int          checks = 0;
    int          fails = 0;

    thirty_two_bit_adder dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin), .sum(sum), .Cout(cout)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {32'b0, ci};
    endfunction

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic ci);
        @(negedge clk);
        a = x;
        b = y;
        cin = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        cin = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cout, sum} !== 33'h0) begin
            fails++;
            $display("FAIL reset_async got %h expected %h", {cout, sum}, 33'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== 33'h1FFFFFFFF) begin
            fails++;
            $display("FAIL reset_release got %h expected %h", {cout, sum}, 33'h1FFFFFFFF);
        end
    endtask

    task automatic test_directed;
        logic [31:0] va [8] = '{32'h0, 32'h30000000, 32'h7A140000, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'h80000000};
        logic [31:0] vb [8] = '{32'h0, 32'h40000000, 32'h66060000, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h0, 32'h1, 32'h80000000};
        logic        vc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [32:0] ve [8] = '{33'h0, 33'h070000000, 33'h0E01A0001, 33'h1FFFFFFFF,
                                33'h1FFFFFFFE, 33'h100000000, 33'h000010000, 33'h100000000};
        for (int n = 0; n < 8; n++) begin
            drive(va[n], vb[n], vc[n]);
            checks++;
            if ({cout, sum} !== ve[n]) begin
                fails++;
                $display("FAIL directed_%0d got %h expected %h", n, {cout, sum}, ve[n]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x, y;
        logic        ci;
        logic [32:0] exp;
        for (int n = 0; n < 1000; n++) begin
            x = $urandom;
            y = $urandom;
            ci = 1'($urandom_range(0, 1));
            if (n % 7 == 0) y = ~x;
            exp = ref_add(x, y, ci);
            drive(x, y, ci);
            checks++;
            if ({cout, sum} !== exp) begin
                fails++;
                $display("FAIL random_%0d a=%h b=%h cin=%b got %h expected %h", n, x, y, ci, {cout, sum}, exp);
            end
        end
    endtask

    task automatic test_midreset;
        logic [32:0] exp;
        drive(32'h12345678, 32'hF0000000, 1'b1);
        checks++;
        if ({cout, sum} !== 33'h102345679) begin
            fails++;
            $display("FAIL pre_reset got %h expected %h", {cout, sum}, 33'h102345679);
        end
        @(negedge clk);
        a = 32'hDEADBEEF;
        b = 32'hCAFEF00D;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cout, sum} !== 33'h0) begin
            fails++;
            $display("FAIL midreset_clear got %h expected %h", {cout, sum}, 33'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== 33'h0) begin
            fails++;
            $display("FAIL midreset_hold got %h expected %h", {cout, sum}, 33'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = ref_add(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({cout, sum} !== exp) begin
            fails++;
            $display("FAIL midreset_resume got %h expected %h", {cout, sum}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
